// File: rtl/mod_updown_counter.sv
// Parametrised synchronous up/down modulo counter with enable, load, clear, prescaler and tc/wrap flags.
// Build option: define COUNTER_SATURATE_EN to saturate at the count limits instead of wrapping.
`default_nettype none

module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam int               PSW     = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [PSW-1:0]   PS_LAST = PSW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PSW-1:0]   ps_q, ps_d;
  logic             wrap_q, wrap_d;

  logic step;
  logic at_max;
  logic at_zero;
  logic load_over;

  assign step      = en && (ps_q == PS_LAST);
  assign at_max    = (cnt_q == MAX_VAL);
  assign at_zero   = (cnt_q == '0);
  // Compare one bit wider so MODULUS == 2**WIDTH never clamps.
  assign load_over = ({1'b0, load_val} >= MOD_EXT);

  always_comb begin
    cnt_d  = cnt_q;
    ps_d   = ps_q;
    wrap_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
      ps_d  = '0;
    end else if (load) begin
      cnt_d = load_over ? MAX_VAL : load_val;
      ps_d  = '0;
    end else if (en) begin
      if (step) begin
        ps_d = '0;
        if (up_dn) begin
          if (at_max) begin
`ifdef COUNTER_SATURATE_EN
            cnt_d  = MAX_VAL;
`else
            cnt_d  = '0;
            wrap_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
            cnt_d  = '0;
`else
            cnt_d  = MAX_VAL;
            wrap_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end else begin
        ps_d = ps_q + PSW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      ps_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ps_q   <= ps_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  // Terminal count follows up_dn combinationally so a direction change is flagged at once.
  assign tc   = up_dn ? at_max : at_zero;
  assign wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter: vector table plus hand sequences for reset and prescaler.
`timescale 1ns/1ps

module tb_mod_updown_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    bit       clr;
    bit       ld;
    bit [3:0] lv;
    bit       en;
    bit       up;
    bit [3:0] q;
    bit       tc;
    bit       wr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up_dn, load, clear;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap;

  logic       p_en, p_up, p_load, p_clear;
  logic [3:0] p_load_val;
  logic [3:0] p_q;
  logic       p_tc, p_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clear(clear), .q(q), .tc(tc), .wrap(wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_ps (
    .clk(clk), .reset(reset), .en(p_en), .up_dn(p_up), .load(p_load),
    .load_val(p_load_val), .clear(p_clear), .q(p_q), .tc(p_tc), .wrap(p_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit clr, input bit ld, input bit [3:0] lv, input bit e,
                     input bit up, input bit [3:0] eq, input bit etc, input bit ewr);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.en = e; v.up = up;
    v.q = eq; v.tc = etc; v.wr = ewr;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit clr, input bit ld, input bit [3:0] lv, input bit e, input bit up);
    clear = clr; load = ld; load_val = lv; en = e; up_dn = up;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 4'd0, 0, 1);
    p_en = 0; p_up = 1; p_load = 0; p_clear = 0; p_load_val = 4'd0;

    // Up wrap from 0: q=1..9, then back to 0 with a wrap pulse.
    for (int i = 0; i < 9; i++) add(0, 0, 4'd0, 1, 1, 4'(i + 1), (i + 1) == 9, 0);
    add(0, 0, 0, 1, 1, SAT ? 4'd9 : 4'd0, SAT, !SAT);
    add(0, 0, 0, 0, 1, SAT ? 4'd9 : 4'd0, SAT, 0);
    // Down wrap from a loaded 1.
    add(0, 1, 4'd1, 0, 0, 4'd1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd0, 1, 0);
    add(0, 0, 0, 1, 0, SAT ? 4'd0 : 4'd9, SAT, !SAT);
    add(0, 0, 0, 1, 0, SAT ? 4'd0 : 4'd8, SAT, 0);
    // Priority clear > load > count, and load clamping.
    add(1, 1, 4'd7, 1, 1, 4'd0, 0, 0);
    add(0, 1, 4'd7, 0, 1, 4'd7, 0, 0);
    add(0, 1, 4'd12, 0, 1, 4'd9, 1, 0);
    add(0, 1, 4'd3, 1, 0, 4'd3, 0, 0);
    add(1, 0, 4'd0, 0, 0, 4'd0, 1, 0);
    add(0, 1, 4'd15, 1, 0, 4'd9, 0, 0);
    // Direction change, one-cycle wrap, clear after wrap.
    add(0, 0, 0, 1, 1, SAT ? 4'd9 : 4'd0, SAT, !SAT);
    add(0, 0, 0, 1, 1, SAT ? 4'd9 : 4'd1, SAT, 0);
    add(0, 1, 4'd9, 0, 1, 4'd9, 1, 0);
    add(0, 0, 0, 1, 1, SAT ? 4'd9 : 4'd0, SAT, !SAT);
    add(1, 0, 0, 1, 1, 4'd0, 0, 0);

    // Reset state.
    tick(); tick();
    check("reset_q", q, 0);
    check("reset_wrap", wrap, 0);
    up_dn = 1; #1;
    check("reset_tc_up", tc, 0);
    up_dn = 0; #1;
    check("reset_tc_dn", tc, 1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up);
      tick();
      $display("vec %0d: clr=%0d ld=%0d lv=%0d en=%0d up=%0d -> q=%0d tc=%0d wrap=%0d", i,
               vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up, q, tc, wrap);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_tc", i), tc, vecs[i].tc);
      check($sformatf("vec%0d_wrap", i), wrap, vecs[i].wr);
    end

    // Reset asserted between edges takes effect immediately and holds q at 0.
    drive(0, 1, 4'd5, 0, 1); tick();
    check("midreset_load", q, 5);
    drive(0, 0, 4'd0, 1, 1);
    #3 reset = 1'b1; #1;
    $display("async reset mid-count: q=%0d wrap=%0d", q, wrap);
    check("midreset_q_now", q, 0);
    check("midreset_wrap_now", wrap, 0);
    tick(); check("midreset_hold1", q, 0);
    tick(); check("midreset_hold2", q, 0);
    #3 reset = 1'b0;
    tick(); check("midreset_restart", q, 1);

    // Reset clears a pending wrap pulse at once.
    drive(0, 1, 4'd9, 0, 1); tick();
    drive(0, 0, 4'd0, 1, 1); tick();
    check("wrap_before_reset", wrap, !SAT);
    #3 reset = 1'b1; #1;
    check("wrap_after_reset", wrap, 0);
    tick();
    #3 reset = 1'b0;
    drive(0, 0, 4'd0, 0, 1);

    // Saturate-vs-wrap sequence: up from 8 for 4 steps, down from 1 for 2 steps.
    begin
      bit [3:0] exp_up[4];
      bit [3:0] exp_dn[2];
      exp_up[0] = 4'd9;
      exp_up[1] = SAT ? 4'd9 : 4'd0;
      exp_up[2] = SAT ? 4'd9 : 4'd1;
      exp_up[3] = SAT ? 4'd9 : 4'd2;
      exp_dn[0] = 4'd0;
      exp_dn[1] = SAT ? 4'd0 : 4'd9;
      drive(0, 1, 4'd8, 0, 1); tick();
      for (int i = 0; i < 4; i++) begin
        drive(0, 0, 4'd0, 1, 1); tick();
        $display("limit up step %0d: q=%0d wrap=%0d", i, q, wrap);
        check($sformatf("limit_up%0d_q", i), q, exp_up[i]);
        check($sformatf("limit_up%0d_wrap", i), wrap, (!SAT && i == 1) ? 1 : 0);
      end
      drive(0, 1, 4'd1, 0, 0); tick();
      for (int i = 0; i < 2; i++) begin
        drive(0, 0, 4'd0, 1, 0); tick();
        $display("limit down step %0d: q=%0d wrap=%0d", i, q, wrap);
        check($sformatf("limit_dn%0d_q", i), q, exp_dn[i]);
        check($sformatf("limit_dn%0d_tc", i), tc, (exp_dn[i] == 0) ? 1 : 0);
      end
      drive(0, 0, 4'd0, 0, 1);
    end

    // Prescaler (PRESCALE=3): step on every third enabled edge.
    p_en = 1; p_up = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      $display("prescale edge %0d: q=%0d", k, p_q);
      check($sformatf("ps_edge%0d_q", k), p_q, k / 3);
    end
    begin
      bit en_seq[5];
      en_seq[0] = 1; en_seq[1] = 0; en_seq[2] = 0; en_seq[3] = 1; en_seq[4] = 1;
      for (int k = 0; k < 5; k++) begin
        p_en = en_seq[k]; tick();
        $display("prescale gap edge %0d: en=%0d q=%0d", k, en_seq[k], p_q);
        check($sformatf("ps_gap%0d_q", k), p_q, (k == 4) ? 4 : 3);
      end
    end
    // Reset mid-period restarts the prescaler from zero.
    p_en = 1; tick();
    #3 reset = 1'b1; #1;
    check("ps_reset_q", p_q, 0);
    #1 reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      $display("prescale after reset edge %0d: q=%0d", k, p_q);
      check($sformatf("ps_fresh%0d_q", k), p_q, (k == 3) ? 1 : 0);
    end
    p_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
